// File: rtl/mmr_scrubbed_register_array.sv
// DEPTH x N register file with K_MMR replicas per word, majority-voted reads and a background scrubber.
// Define MMR_FAULT_INJECT_EN to add the single-bit fault injection port (inj_*).
module mmr_scrubbed_register_array #(
    parameter int  K_MMR        = 3,
    parameter int  N            = 16,
    parameter int  DEPTH        = 8,
    parameter int  SCRUB_PERIOD = 16,
    parameter int  CNT_W        = 8,
    localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            waddr_i,
    input  logic [N-1:0]             wdata_i,
    input  logic                     re_i,
    input  logic [AW-1:0]            raddr_i,
    output logic [N-1:0]             rdata_o,
    output logic                     rvalid_o,
    output logic                     rd_mismatch_o,
    input  logic                     scrub_en_i,
    output logic                     scrub_busy_o,
    output logic [CNT_W-1:0]         corr_cnt_o,
    output logic [K_MMR-1:0]         replica_err_o,
`ifdef MMR_FAULT_INJECT_EN
    input  logic                     inj_i,
    input  logic [AW-1:0]            inj_addr_i,
    input  logic [$clog2(K_MMR)-1:0] inj_replica_i,
    input  logic [$clog2(N)-1:0]     inj_bit_i,
`endif
    input  logic                     clr_err_i
);

    localparam int PW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_CHECK = 2'd1,
        S_FIX   = 2'd2
    } state_e;

    typedef logic [K_MMR-1:0][N-1:0] reps_t;

    function automatic logic [N-1:0] vote_f(input reps_t reps);
        logic [N-1:0] v;
        int           ones;
        v = '0;
        for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int k = 0; k < K_MMR; k++) begin
                ones += int'(reps[k][b]);
            end
            v[b] = (ones > (K_MMR / 2));
        end
        return v;
    endfunction

    function automatic logic [K_MMR-1:0] losers_f(input reps_t reps, input logic [N-1:0] voted);
        logic [K_MMR-1:0] l;
        l = '0;
        for (int k = 0; k < K_MMR; k++) begin
            l[k] = (reps[k] != voted);
        end
        return l;
    endfunction

    logic [K_MMR-1:0][DEPTH-1:0][N-1:0] mem_q, mem_d;
    state_e                             state_q, state_d;
    logic [AW-1:0]                      saddr_q, saddr_d;
    logic [PW-1:0]                      pcnt_q, pcnt_d;
    logic [CNT_W-1:0]                   corr_q, corr_d;
    logic [K_MMR-1:0]                   err_q, err_d;
    logic [N-1:0]                       rdata_q, rdata_d;
    logic                               rvalid_q, rvalid_d;
    logic                               rmis_q, rmis_d;
    logic                               busy_q;

    reps_t                              rd_reps_s, sc_reps_s;
    logic [N-1:0]                       rd_vote_s, sc_vote_s;
    logic [K_MMR-1:0]                   rd_lose_s, sc_lose_s, err_set_s;
    logic [AW-1:0]                      saddr_nxt_s;
    logic                               sc_mis_s, wr_hit_s, fix_en_s, corr_inc_s;
`ifdef MMR_FAULT_INJECT_EN
    logic                               inj_ok_s;
`endif

    // Replica views of the word being read and the word under scrub
    always_comb begin
        rd_reps_s = '0;
        sc_reps_s = '0;
        for (int k = 0; k < K_MMR; k++) begin
            rd_reps_s[k] = mem_q[k][raddr_i];
            sc_reps_s[k] = mem_q[k][saddr_q];
        end
    end

    assign rd_vote_s   = vote_f(rd_reps_s);
    assign rd_lose_s   = losers_f(rd_reps_s, rd_vote_s);
    assign sc_vote_s   = vote_f(sc_reps_s);
    assign sc_lose_s   = losers_f(sc_reps_s, sc_vote_s);
    assign sc_mis_s    = |sc_lose_s;
    assign saddr_nxt_s = (saddr_q == AW'(DEPTH - 1)) ? '0 : saddr_q + AW'(1);
    assign wr_hit_s    = we_i && (waddr_i == saddr_q);
`ifdef MMR_FAULT_INJECT_EN
    assign inj_ok_s    = inj_i && !(we_i && (waddr_i == inj_addr_i))
                         && (int'(inj_replica_i) < K_MMR) && (int'(inj_bit_i) < N);
`endif

    // Scrub FSM next-state; a step in progress always finishes before parking in S_WAIT
    always_comb begin
        state_d    = state_q;
        saddr_d    = saddr_q;
        pcnt_d     = pcnt_q;
        fix_en_s   = 1'b0;
        corr_inc_s = 1'b0;
        err_set_s  = '0;
        case (state_q)
            S_WAIT: begin
                if (scrub_en_i) begin
                    if (pcnt_q == PW'(SCRUB_PERIOD - 1)) begin
                        pcnt_d  = '0;
                        state_d = S_CHECK;
                    end else begin
                        pcnt_d  = pcnt_q + PW'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q;
                end
            end
            S_CHECK: begin
                if (sc_mis_s) begin
                    err_set_s = sc_lose_s;
                    state_d   = S_FIX;
                end else begin
                    saddr_d   = saddr_nxt_s;
                    state_d   = S_WAIT;
                end
            end
            S_FIX: begin
                saddr_d    = saddr_nxt_s;
                state_d    = S_WAIT;
                fix_en_s   = !wr_hit_s;
                corr_inc_s = !wr_hit_s;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Storage update: scrub fix, then injection, then host write (host write wins)
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < K_MMR; k++) begin
            mem_d[k][saddr_q] = fix_en_s ? sc_vote_s : mem_q[k][saddr_q];
        end
`ifdef MMR_FAULT_INJECT_EN
        for (int k = 0; k < K_MMR; k++) begin
            mem_d[k][inj_addr_i][inj_bit_i] = mem_d[k][inj_addr_i][inj_bit_i]
                                              ^ (inj_ok_s && (int'(inj_replica_i) == k));
        end
`endif
        for (int k = 0; k < K_MMR; k++) begin
            mem_d[k][waddr_i] = we_i ? wdata_i : mem_d[k][waddr_i];
        end
    end

    // Read port and sticky status; clr_err_i overrides any same-cycle update
    always_comb begin
        rdata_d  = re_i ? rd_vote_s : rdata_q;
        rvalid_d = re_i;
        rmis_d   = re_i && (|rd_lose_s);
        err_d    = clr_err_i ? '0
                 : (err_q | err_set_s | (re_i ? rd_lose_s : {K_MMR{1'b0}}));
        corr_d   = clr_err_i ? '0
                 : ((corr_inc_s && (corr_q != {CNT_W{1'b1}})) ? corr_q + CNT_W'(1) : corr_q);
    end

    // State, storage and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '0;
            state_q  <= S_WAIT;
            saddr_q  <= '0;
            pcnt_q   <= '0;
            corr_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rmis_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            state_q  <= state_d;
            saddr_q  <= saddr_d;
            pcnt_q   <= pcnt_d;
            corr_q   <= corr_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rmis_q   <= rmis_d;
            busy_q   <= (state_d != S_WAIT);
        end
    end

    assign rdata_o       = rdata_q;
    assign rvalid_o      = rvalid_q;
    assign rd_mismatch_o = rmis_q;
    assign scrub_busy_o  = busy_q;
    assign corr_cnt_o    = corr_q;
    assign replica_err_o = err_q;

endmodule

// File: tb/tb_mmr_scrubbed_register_array.sv
// Scoreboard bench for mmr_scrubbed_register_array: a replica-array model predicts reads,
// sticky replica errors and the saturating correction count.
module tb_mmr_scrubbed_register_array;

    localparam int K  = 3;
    localparam int N  = 8;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int CW = 2;

    logic          clk_i      = 1'b0;
    logic          rst_n_i    = 1'b0;
    logic          we_i       = 1'b0;
    logic [AW-1:0] waddr_i    = 3'd0;
    logic [N-1:0]  wdata_i    = 8'd0;
    logic          re_i       = 1'b0;
    logic [AW-1:0] raddr_i    = 3'd0;
    logic          scrub_en_i = 1'b0;
    logic          clr_err_i  = 1'b0;
    logic [N-1:0]  rdata_o;
    logic          rvalid_o;
    logic          rd_mismatch_o;
    logic          scrub_busy_o;
    logic [CW-1:0] corr_cnt_o;
    logic [K-1:0]  replica_err_o;
`ifdef MMR_FAULT_INJECT_EN
    logic          inj_i         = 1'b0;
    logic [AW-1:0] inj_addr_i    = 3'd0;
    logic [1:0]    inj_replica_i = 2'd0;
    logic [2:0]    inj_bit_i     = 3'd0;
`endif

    mmr_scrubbed_register_array #(
        .K_MMR(K), .N(N), .DEPTH(D), .SCRUB_PERIOD(4), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .re_i(re_i), .raddr_i(raddr_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rd_mismatch_o(rd_mismatch_o),
        .scrub_en_i(scrub_en_i), .scrub_busy_o(scrub_busy_o),
        .corr_cnt_o(corr_cnt_o), .replica_err_o(replica_err_o),
`ifdef MMR_FAULT_INJECT_EN
        .inj_i(inj_i), .inj_addr_i(inj_addr_i),
        .inj_replica_i(inj_replica_i), .inj_bit_i(inj_bit_i),
`endif
        .clr_err_i(clr_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [N-1:0] d;
        logic         m;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] mem_m [K][D];
    logic [K-1:0] err_m;
    int           corr_m;
    int           n_cmp  = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] vote_m(input int a);
        logic [N-1:0] v;
        int           ones;
        v = '0;
        for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int k = 0; k < K; k++) ones += mem_m[k][a][b] ? 1 : 0;
            v[b] = (ones > K / 2);
        end
        return v;
    endfunction

    function automatic logic [K-1:0] losers_m(input int a);
        logic [K-1:0] l;
        logic [N-1:0] v;
        v = vote_m(a);
        for (int k = 0; k < K; k++) l[k] = (mem_m[k][a] != v);
        return l;
    endfunction

    task automatic reset_m();
        for (int k = 0; k < K; k++)
            for (int a = 0; a < D; a++) mem_m[k][a] = '0;
        err_m  = '0;
        corr_m = 0;
    endtask

    // Outcome of one complete scrub pass, independent of the order words are visited
    task automatic scrub_all_m();
        logic [K-1:0] l;
        logic [N-1:0] v;
        for (int a = 0; a < D; a++) begin
            l = losers_m(a);
            if (l != '0) begin
                v = vote_m(a);
                err_m |= l;
                for (int k = 0; k < K; k++) mem_m[k][a] = v;
                if (corr_m < 3) corr_m++;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic clr);
        exp_t e;
        we_i = we; waddr_i = wa; wdata_i = wd;
        re_i = re; raddr_i = ra; clr_err_i = clr;
`ifdef MMR_FAULT_INJECT_EN
        inj_i = 1'b0;
`endif
        if (re) begin
            e.d = vote_m(int'(ra));
            e.m = (losers_m(int'(ra)) != '0);
            sb_q.push_back(e);
            err_m |= losers_m(int'(ra));
        end
        if (clr) begin
            err_m  = '0;
            corr_m = 0;
        end
        if (we) for (int k = 0; k < K; k++) mem_m[k][int'(wa)] = wd;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic rd(input int a);
        cyc(); drive(1'b0, 3'd0, 8'd0, 1'b1, AW'(a), 1'b0);
        cyc(); idle();
    endtask

`ifdef MMR_FAULT_INJECT_EN
    task automatic inject(input int a, input int r, input int b);
        inj_i = 1'b1; inj_addr_i = AW'(a); inj_replica_i = 2'(r); inj_bit_i = 3'(b);
        if (!(we_i && int'(waddr_i) == a) && r < K) mem_m[r][a][b] = ~mem_m[r][a][b];
    endtask
`endif

    task automatic scrub_window();
        scrub_en_i = 1'b1;
        repeat (60) begin cyc(); idle(); end
        scrub_en_i = 1'b0;
        repeat (4) begin cyc(); idle(); end
        scrub_all_m();
    endtask

    // Returns at the negedge inside the second consecutive busy cycle, i.e. S_FIX
    task automatic find_fix(output bit found);
        bit prev;
        prev  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc();
            if (scrub_busy_o && prev) found = 1'b1;
            else begin
                prev = scrub_busy_o;
                idle();
            end
        end
    endtask

    task automatic reset_mid_scrub();
        rst_n_i = 1'b0; scrub_en_i = 1'b0;
        idle();
        #1;
        chk("midrst_rdata", 32'(rdata_o), 32'd0);
        chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
        chk("midrst_mismatch", 32'(rd_mismatch_o), 32'd0);
        chk("midrst_corr", 32'(corr_cnt_o), 32'd0);
        chk("midrst_err", 32'(replica_err_o), 32'd0);
        chk("midrst_busy", 32'(scrub_busy_o), 32'd0);
        reset_m();
        cyc(); rst_n_i = 1'b1;
    endtask

    // Monitor: every rvalid_o pulse is matched against the oldest predicted read
    always @(negedge clk_i) begin
        exp_t e;
        if (rvalid_o) begin
            if (sb_q.size() == 0) chk("rvalid_without_read", 32'(sb_q.size()), 32'd1);
            else begin
                e = sb_q.pop_front();
                chk("rdata", 32'(rdata_o), 32'(e.d));
                chk("rd_mismatch", 32'(rd_mismatch_o), 32'(e.m));
            end
        end
    end

    initial begin
        bit found;
        reset_m();
        repeat (2) cyc();
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_mismatch", 32'(rd_mismatch_o), 32'd0);
        chk("rst_corr", 32'(corr_cnt_o), 32'd0);
        chk("rst_err", 32'(replica_err_o), 32'd0);
        chk("rst_busy", 32'(scrub_busy_o), 32'd0);
        cyc(); rst_n_i = 1'b1; idle();

        cyc(); drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0);
        rd(3);

`ifdef MMR_FAULT_INJECT_EN
        cyc(); idle(); inject(3, 1, 0);
        rd(3);
        chk("t2_err", 32'(replica_err_o), 32'h2);
        chk("t2_corr", 32'(corr_cnt_o), 32'd0);

        scrub_window();
        chk("t3_corr", 32'(corr_cnt_o), 32'd1);
        chk("t3_err", 32'(replica_err_o), 32'h2);
        rd(3);

        cyc(); idle(); inject(5, 2, 7);
        cyc(); idle(); scrub_en_i = 1'b1;
        find_fix(found);
        chk("t4_fix_seen", 32'(found), 32'd1);
        err_m |= losers_m(5);
        drive(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0);
        scrub_en_i = 1'b0;
        repeat (4) begin cyc(); idle(); end
        chk("t4_corr", 32'(corr_cnt_o), 32'd1);
        chk("t4_err", 32'(replica_err_o), 32'h6);
        rd(5);
`endif

        for (int i = 0; i < 300; i++) begin
            cyc();
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), N'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
                  1'($urandom_range(0, 31) == 0));
`ifdef MMR_FAULT_INJECT_EN
            if ($urandom_range(0, 2) == 0)
                inject(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, N - 1)));
`endif
        end
        repeat (2) begin cyc(); idle(); end
        chk("rand_err", 32'(replica_err_o), 32'(err_m));
        chk("rand_corr", 32'(corr_cnt_o), 32'(corr_m));
        scrub_window();
        chk("rand_scrub_err", 32'(replica_err_o), 32'(err_m));
        chk("rand_scrub_corr", 32'(corr_cnt_o), 32'(corr_m));
        for (int a = 0; a < D; a++) rd(a);

`ifdef MMR_FAULT_INJECT_EN
        cyc(); drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1);
        cyc(); idle(); inject(0, 0, 1);
        cyc(); idle(); inject(1, 1, 2);
        cyc(); idle(); inject(2, 2, 3);
        cyc(); idle(); inject(4, 0, 4);
        cyc(); idle(); inject(6, 1, 5);
        scrub_window();
        chk("t5_corr_sat", 32'(corr_cnt_o), 32'd3);
        chk("t5_err", 32'(replica_err_o), 32'(err_m));
        cyc(); drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1);
        cyc(); idle();
        chk("t5_clr_corr", 32'(corr_cnt_o), 32'd0);
        chk("t5_clr_err", 32'(replica_err_o), 32'd0);

        cyc(); idle(); inject(2, 0, 4);
        cyc(); idle(); scrub_en_i = 1'b1;
        find_fix(found);
        chk("t6_fix_seen", 32'(found), 32'd1);
        reset_mid_scrub();
        rd(2);
        rd(3);
        cyc(); idle(); inject(0, 1, 6); scrub_en_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(); idle();
            if (corr_cnt_o == 2'd1) found = 1'b1;
        end
        chk("t6_restart_at_addr0", 32'(found), 32'd1);
        scrub_en_i = 1'b0;
        repeat (4) begin cyc(); idle(); end
        scrub_all_m();
        chk("t6_corr", 32'(corr_cnt_o), 32'(corr_m));
        chk("t6_err", 32'(replica_err_o), 32'(err_m));
        rd(0);
`else
        cyc(); idle(); scrub_en_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (scrub_busy_o) found = 1'b1;
            else idle();
        end
        chk("t6_busy_seen", 32'(found), 32'd1);
        reset_mid_scrub();
        rd(3);
`endif

        repeat (3) begin cyc(); idle(); end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
